tick_mem_loader: RTL
====================

// Module: tick_mem_loader
// PURPOSE
//  Writer side of the timingCore tick/pixel memory port. Accepts a valid/ready stream of
//  {active_pixel, dt_ticks} words, writes them line by line into the frame memories via
//  waddr/wdata/we/memory_selector, then answers timingCore's update_mem request with a
//  one-cycle mem_updated pulse. Replaces the software fill sequence in hardware.
// PARAMETERS
//  ADDR_W      11  tick-memory address width (matches timingCore waddr_i)
//  DATA_W      17  word width: [16] active_pixel, [15:0] dt_ticks
//  MAX_FRAMES  5   number of frame memories behind memory_selector
// PORTS
//  clk_i               in   1       system clock
//  rst_i               in   1       synchronous reset, active-high
//  start_i             in   1       begin a load (sampled in IDLE only)
//  abort_i             in   1       cancel any load, return to IDLE
//  points_per_line_i   in   10      words per frame memory (latched on start)
//  number_of_frames_i  in   3       frame memories to fill (latched on start)
//  s_valid_i           in   1       stream word valid
//  s_data_i            in   DATA_W  stream word
//  s_ready_o           out  1       loader accepts word this cycle
//  waddr_o             out  ADDR_W  to timingCore waddr_i
//  wdata_o             out  DATA_W  to timingCore wdata_i
//  we_o                out  1       to timingCore we_i
//  memory_selector_o   out  3       to timingCore memory_selector_i
//  update_mem_i        in   1       from timingCore update_mem_o (request for new memory)
//  mem_updated_o       out  1       to timingCore mem_updated_i, 1-cycle pulse
//  busy_o              out  1       high in any state other than IDLE
//  err_o               out  1       sticky config error; cleared by rst_i or next valid start
//  checksum_o          out  16      tick checksum (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; latched config, addr, frame, update_mem edge reg = 0.
//  FSM IDLE -> LOAD -> COMMIT -> IDLE.
//  IDLE: s_ready_o=0. start_i: if ppl==0 or nframes==0 or nframes>MAX_FRAMES -> err_o=1,
//   stay IDLE; else latch ppl/nframes, addr=0, frame=0, err_o=0, checksum=0 -> LOAD.
//  LOAD: s_ready_o=1 (combinational from state). Handshake on s_valid_i & s_ready_o.
//   Accepted word -> next cycle we_o=1, waddr_o=addr, wdata_o=s_data_i,
//   memory_selector_o=frame (1-cycle latency, registered). we_o=0 in cycles w/o accept.
//   addr increments per accept; at addr==ppl-1: addr=0; if frame==nframes-1 -> COMMIT,
//   else frame+1. s_ready_o drops the cycle after the last word is accepted.
//   s_valid_i gaps allowed; no timeout.
//  COMMIT: s_ready_o=0, we_o=0. Waits for rising edge of update_mem_i (registered edge
//   detect; level already high on entry does not count). On edge: mem_updated_o=1 for
//   exactly one cycle, -> IDLE. memory_selector_o holds last frame index until next write.
//  abort_i (any state, priority over start_i and stream accept): -> IDLE next cycle,
//   no write that cycle, no mem_updated pulse, err_o unchanged.
//  start_i outside IDLE ignored. Simultaneous last accept and abort: abort wins, word dropped.
//  waddr_o zero-extends the 10-bit addr to ADDR_W.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: checksum_o = running 16-bit wrap-around sum of s_data_i[15:0]
//   over all accepted words since last valid start; updated same cycle as we_o.
//  Not defined: checksum_o tied to 16'd0, no accumulator logic.
// TESTING
//  ppl=360, nframes=1, ticks=5 continuous -> 360 we_o pulses, waddr 0..359, selector 0,
//   busy_o high throughout, COMMIT after addr 359.
//  ppl=4, nframes=3, s_valid_i every other cycle -> 12 writes, selector 0,0,0,0,1..,2..;
//   s_ready_o low after 12th accept.
//  In COMMIT with update_mem_i already 1 -> no pulse; drop to 0 then 1 -> mem_updated_o one
//   cycle, then IDLE.
//  start with ppl=0, or nframes=6 -> err_o=1, busy_o=0, no writes; later valid start -> err_o=0.
//  abort_i after 100 of 360 words -> IDLE next cycle, we_o=0, no mem_updated; restart loads
//   from addr 0.
//  LOADER_CHECKSUM_EN, 4 words 0xFFFF,0x0002,0x0001,0x0000 -> checksum_o=0x0002; undefined -> 0.

Source files
------------

// File: rtl/tick_mem_loader.sv
// tick_mem_loader: writer side of the timingCore tick/pixel memory port.
// Accepts a valid/ready stream of {active_pixel, dt_ticks} words and writes them
// line by line into the frame memories. When the frames are full it waits for
// timingCore's update_mem request and answers with a one-cycle mem_updated pulse.
// Optional feature macro: LOADER_CHECKSUM_EN (running 16-bit tick checksum).
module tick_mem_loader #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 17,
  parameter int MAX_FRAMES = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [9:0]        points_per_line_i,
  input  logic [2:0]        number_of_frames_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              we_o,
  output logic [2:0]        memory_selector_o,
  input  logic              update_mem_i,
  output logic              mem_updated_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [15:0]       checksum_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [9:0]        ppl_q, ppl_d;
  logic [2:0]        nfr_q, nfr_d;
  logic [9:0]        addr_q, addr_d;
  logic [2:0]        frame_q, frame_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        sel_q, sel_d;
  logic              mupd_q, mupd_d;
  logic              err_q, err_d;
  logic              upd_q, upd_d;

  logic accept;
  logic upd_edge;
  logic cfg_bad;
  logic last_in_line;
  logic last_frame;

  // Stream handshake: ready purely from state; abort suppresses the accept.
  assign s_ready_o    = (state_q == S_LOAD);
  assign accept       = s_valid_i & s_ready_o & ~abort_i;
  // Edge detect against the previous level so a request already high on entry is ignored.
  assign upd_edge     = update_mem_i & ~upd_q;
  assign cfg_bad      = (points_per_line_i == 10'd0) || (number_of_frames_i == 3'd0) ||
                        (32'(number_of_frames_i) > MAX_FRAMES);
  assign last_in_line = (addr_q == 10'(ppl_q - 10'd1));
  assign last_frame   = (frame_q == 3'(nfr_q - 3'd1));

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] cksum_q, cksum_d;
  assign checksum_o = cksum_q;
`else
  assign checksum_o = 16'd0;
`endif

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ppl_q   <= '0;
      nfr_q   <= '0;
      addr_q  <= '0;
      frame_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      mupd_q  <= 1'b0;
      err_q   <= 1'b0;
      upd_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ppl_q   <= ppl_d;
      nfr_q   <= nfr_d;
      addr_q  <= addr_d;
      frame_q <= frame_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      mupd_q  <= mupd_d;
      err_q   <= err_d;
      upd_q   <= upd_d;
`ifdef LOADER_CHECKSUM_EN
      cksum_q <= cksum_d;
`endif
    end
  end

  // Next-state logic: abort has priority over start and over stream accepts.
  always_comb begin
    state_d = state_q;
    ppl_d   = ppl_q;
    nfr_d   = nfr_q;
    addr_d  = addr_q;
    frame_d = frame_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    mupd_d  = 1'b0;
    err_d   = err_q;
    upd_d   = update_mem_i;
`ifdef LOADER_CHECKSUM_EN
    cksum_d = cksum_q;
`endif
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (cfg_bad) begin
              err_d = 1'b1;
            end else begin
              ppl_d   = points_per_line_i;
              nfr_d   = number_of_frames_i;
              addr_d  = '0;
              frame_d = '0;
              err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
              cksum_d = '0;
`endif
              state_d = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            we_d    = 1'b1;
            waddr_d = ADDR_W'(addr_q);
            wdata_d = s_data_i;
            sel_d   = frame_q;
`ifdef LOADER_CHECKSUM_EN
            cksum_d = cksum_q + s_data_i[15:0];
`endif
            if (last_in_line) begin
              addr_d = '0;
              if (last_frame) state_d = S_COMMIT;
              else            frame_d = frame_q + 3'd1;
            end else begin
              addr_d = addr_q + 10'd1;
            end
          end
        end
        S_COMMIT: begin
          if (upd_edge) begin
            mupd_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign waddr_o           = waddr_q;
  assign wdata_o           = wdata_q;
  assign we_o              = we_q;
  assign memory_selector_o = sel_q;
  assign mem_updated_o     = mupd_q;
  assign err_o             = err_q;
  assign busy_o            = (state_q != S_IDLE);

endmodule
